// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared types: bus owner codes, FSM states, store buffer entry.
// The entry packs {addr, we, wdata} into 68 bits.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_IF = 2'd0,
        OWN_DR = 2'd1,
        OWN_WR = 2'd2
    } owner_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } wbuf_entry_t;

    localparam int ENTRY_W = $bits(wbuf_entry_t);

endpackage

// File: rtl/mem_wbuf.sv
// mem_wbuf: synchronous store FIFO with the head and the entry behind it
// visible combinationally.
module mem_wbuf
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  wbuf_entry_t           din,
    output wbuf_entry_t           head,
    output wbuf_entry_t           second,
    output logic [$clog2(DEPTH):0] count,
    output logic                  full,
    output logic                  empty
);
    localparam int PTR_W = $clog2(DEPTH);

    wbuf_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_nx;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign rd_nx  = rd_ptr + 1'b1;
    assign head   = mem[rd_ptr];
    assign second = mem[rd_nx];
    assign full   = (count == (PTR_W + 1)'(DEPTH));
    assign empty  = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: one RAM port shared by instruction fetch, loads and posted
// stores. Reads answer with a ready pulse; stores drain in order.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WBUF_DEPTH = 4,
    parameter int IADDR_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IADDR_W-1:0] imem_addr,
    input  logic               imem_oe,
    output logic [31:0]        imem_rdata,
    output logic               imem_ready,
    input  logic [31:0]        mem_addr,
    input  logic               mem_oe,
    input  logic [31:0]        mem_wdata,
    input  logic [3:0]         mem_we,
    output logic [31:0]        mem_rdata,
    output logic               mem_ready,
    output logic               ram_req,
    output logic [31:0]        ram_addr,
    output logic [3:0]         ram_we,
    output logic [31:0]        ram_wdata,
    input  logic               ram_ack,
    input  logic [31:0]        ram_rdata,
    output logic               wbuf_full,
    output logic               wbuf_overflow
);
    localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;

    state_t             state, state_nx;
    owner_t             owner, owner_nx;
    logic               if_pend, dr_pend;
    logic [IADDR_W-1:0] if_addr;
    logic [31:0]        dr_addr;
    logic               if_acc, dr_acc, st_acc;
    logic               done, push, pop;
    logic               if_cand, dr_cand, wr_cand, wr_urgent, grant;
    logic [31:0]        gnt_addr, gnt_wdata;
    logic [3:0]         gnt_we;
    wbuf_entry_t        st_entry, wb_head, wb_second, wr_entry;
    logic [CNT_W-1:0]   wb_count;
    logic               wb_full, wb_empty;

    assign if_acc   = imem_oe && !if_pend;
    assign dr_acc   = mem_oe && (mem_we == 4'b0) && !dr_pend;
    assign st_acc   = mem_oe && (mem_we != 4'b0) && !dr_pend;
    assign done     = (state == ST_BUSY) && ram_ack;
    assign pop      = done && (owner == OWN_WR);
    assign push     = st_acc && (!wb_full || pop);
    assign st_entry = '{addr: mem_addr, we: mem_we, wdata: mem_wdata};

    // Candidates as they stand after this cycle's completion and new requests
    assign if_cand   = (if_pend && !(done && owner == OWN_IF)) || if_acc;
    assign dr_cand   = (dr_pend && !(done && owner == OWN_DR)) || dr_acc;
    assign wr_cand   = !wb_empty && !(pop && wb_count == CNT_W'(1));
    assign wr_urgent = wb_full && !pop;
    assign wr_entry  = pop ? wb_second : wb_head;

    mem_wbuf #(
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .din    (st_entry),
        .head   (wb_head),
        .second (wb_second),
        .count  (wb_count),
        .full   (wb_full),
        .empty  (wb_empty)
    );

    always_comb begin
        grant    = 1'b0;
        owner_nx = owner;
        state_nx = state;
        if (state == ST_IDLE || done) begin
            grant = 1'b1;
            // Loads never overtake older stores
            if (wr_urgent || (dr_cand && wr_cand)) owner_nx = OWN_WR;
            else if (dr_cand)                      owner_nx = OWN_DR;
            else if (if_cand)                      owner_nx = OWN_IF;
            else if (wr_cand)                      owner_nx = OWN_WR;
            else                                   grant    = 1'b0;
            state_nx = grant ? ST_BUSY : ST_IDLE;
        end
        gnt_addr  = '0;
        gnt_we    = '0;
        gnt_wdata = '0;
        unique case (owner_nx)
            OWN_WR: begin
                gnt_addr  = wr_entry.addr;
                gnt_we    = wr_entry.we;
                gnt_wdata = wr_entry.wdata;
            end
            OWN_DR:  gnt_addr = dr_pend ? dr_addr : mem_addr;
            default: gnt_addr = if_pend ? 32'(if_addr) : 32'(imem_addr);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            owner <= OWN_IF;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_req       <= 1'b0;
            ram_addr      <= '0;
            ram_we        <= '0;
            ram_wdata     <= '0;
            imem_rdata    <= '0;
            imem_ready    <= 1'b0;
            mem_rdata     <= '0;
            mem_ready     <= 1'b0;
            if_pend       <= 1'b0;
            dr_pend       <= 1'b0;
            if_addr       <= '0;
            dr_addr       <= '0;
            wbuf_overflow <= 1'b0;
        end else begin
            if (grant) begin
                ram_req   <= 1'b1;
                ram_addr  <= gnt_addr;
                ram_we    <= gnt_we;
                ram_wdata <= gnt_wdata;
            end else if (done) begin
                ram_req <= 1'b0;
            end
            imem_ready <= done && (owner == OWN_IF);
            mem_ready  <= done && (owner == OWN_DR);
            if (done && owner == OWN_IF) imem_rdata <= ram_rdata;
            if (done && owner == OWN_DR) mem_rdata  <= ram_rdata;
            if (if_acc)                       if_pend <= 1'b1;
            else if (done && owner == OWN_IF) if_pend <= 1'b0;
            if (dr_acc)                       dr_pend <= 1'b1;
            else if (done && owner == OWN_DR) dr_pend <= 1'b0;
            if (if_acc) if_addr <= imem_addr;
            if (dr_acc) dr_addr <= mem_addr;
            if (st_acc && !push) wbuf_overflow <= 1'b1;
        end
    end

    assign wbuf_full = wb_full;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests against a program-order memory model and a
// RAM responder with configurable ack delay.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] imem_addr = '0;
    logic        imem_oe = 1'b0;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] mem_addr = '0;
    logic        mem_oe = 1'b0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_we = '0;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        ram_req;
    logic [31:0] ram_addr;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic        ram_ack = 1'b0;
    logic [31:0] ram_rdata = '0;
    logic        wbuf_full;
    logic        wbuf_overflow;

    always #5 clk = ~clk;

    mem_arbiter #(
        .WBUF_DEPTH (4),
        .IADDR_W    (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_oe       (imem_oe),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .mem_addr      (mem_addr),
        .mem_oe        (mem_oe),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .ram_req       (ram_req),
        .ram_addr      (ram_addr),
        .ram_we        (ram_we),
        .ram_wdata     (ram_wdata),
        .ram_ack       (ram_ack),
        .ram_rdata     (ram_rdata),
        .wbuf_full     (wbuf_full),
        .wbuf_overflow (wbuf_overflow)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic miss(string name);
        total++;
        bad++;
        $display("FAIL %s: got none expected event", name);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } op_t;

    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    op_t         op_log [$];
    op_t         exp_wr [$];
    logic [31:0] exp_f [$];
    logic [31:0] exp_l [$];

    function automatic logic [31:0] dflt(logic [31:0] w);
        return 32'hC0DE_0000 ^ w;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d,
                                          logic [3:0] we);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++)
            if (we[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(logic [31:0] a);
        logic [31:0] w = {a[31:2], 2'b00};
        return ref_mem.exists(w) ? ref_mem[w] : dflt(w);
    endfunction

    function automatic logic [31:0] ram_rd(logic [31:0] a);
        logic [31:0] w = {a[31:2], 2'b00};
        return ram_mem.exists(w) ? ram_mem[w] : dflt(w);
    endfunction

    // RAM responder: ack k cycles after the first cycle of a request
    int          k = 1;
    bit          stall = 1'b0;
    bit          late_ack = 1'b0;
    int          age = 0;
    logic [31:0] s_addr, s_wdata, r_w;
    logic [3:0]  s_we;
    op_t         r_o, r_e;

    always @(negedge clk) begin
        ram_ack = 1'b0;
        if (late_ack) begin
            ram_ack   = 1'b1;
            ram_rdata = 32'hBAD0_BAD0;
            late_ack  = 1'b0;
            age       = 0;
        end else if (rst || !ram_req) begin
            age = 0;
        end else begin
            age++;
            if (age == 1) begin
                s_addr  = ram_addr;
                s_we    = ram_we;
                s_wdata = ram_wdata;
            end else begin
                chk("ram_addr_stable", ram_addr, s_addr);
                chk("ram_we_stable", ram_we, s_we);
                chk("ram_wdata_stable", ram_wdata, s_wdata);
            end
            if (age >= k + 1 && !stall) begin
                ram_ack  = 1'b1;
                r_o.addr = ram_addr;
                r_o.we   = ram_we;
                r_o.wdata = ram_wdata;
                op_log.push_back(r_o);
                r_w = {ram_addr[31:2], 2'b00};
                if (ram_we == 4'b0) begin
                    ram_rdata = ram_rd(ram_addr);
                end else begin
                    ram_mem[r_w] = merge(ram_rd(ram_addr), ram_wdata, ram_we);
                    if (exp_wr.size() == 0) begin
                        miss("write_order");
                    end else begin
                        r_e = exp_wr.pop_front();
                        chk("write_addr", ram_addr, r_e.addr);
                        chk("write_we", ram_we, r_e.we);
                        chk("write_wdata", ram_wdata, r_e.wdata);
                    end
                end
                age = 0;
            end
        end
    end

    // Every ready pulse must match the oldest outstanding read of its port
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_ready) begin
                if (exp_f.size() == 0) chk("imem_spurious", imem_ready, 0);
                else chk("imem_rdata", imem_rdata, exp_f.pop_front());
            end
            if (mem_ready) begin
                if (exp_l.size() == 0) chk("mem_spurious", mem_ready, 0);
                else chk("mem_rdata", mem_rdata, exp_l.pop_front());
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic store_exp(logic [31:0] a, logic [3:0] we, logic [31:0] d,
                             bit drop);
        op_t e;
        if (!drop) begin
            ref_mem[{a[31:2], 2'b00}] = merge(ref_rd(a), d, we);
            e.addr  = a;
            e.we    = we;
            e.wdata = d;
            exp_wr.push_back(e);
        end
    endtask

    task automatic do_load(logic [31:0] a, output logic [31:0] got);
        bit seen = 1'b0;
        mem_addr = a;
        mem_we   = 4'b0;
        mem_oe   = 1'b1;
        exp_l.push_back(ref_rd(a));
        tick();
        mem_oe = 1'b0;
        got    = 'x;
        for (int n = 0; n < 60 && !seen; n++) begin
            if (mem_ready) begin
                got  = mem_rdata;
                seen = 1'b1;
            end else begin
                tick();
            end
        end
        if (!seen) miss("load_timeout");
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int n = 0; n < 300 && !idle; n++) begin
            tick();
            idle = !ram_req && exp_f.size() == 0 && exp_l.size() == 0 &&
                   exp_wr.size() == 0;
        end
        if (!idle) miss("idle_timeout");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        int          mc, ic, nr;

        repeat (3) tick();
        chk("rst_ram_req", ram_req, 0);
        chk("rst_imem_ready", imem_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_wbuf_full", wbuf_full, 0);
        chk("rst_overflow", wbuf_overflow, 0);
        chk("rst_imem_rdata", imem_rdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_ram_addr", ram_addr, 0);
        rst = 1'b0;
        tick();

        // Single fetch, ack one cycle after req
        imem_addr = 16'h0010;
        imem_oe   = 1'b1;
        exp_f.push_back(ref_rd(32'h10));
        tick();
        imem_oe = 1'b0;
        chk("f1_ram_req", ram_req, 1);
        chk("f1_ram_addr", ram_addr, 32'h0000_0010);
        chk("f1_ram_we", ram_we, 0);
        tick();
        chk("f1_not_ready_yet", imem_ready, 0);
        tick();
        chk("f1_ready", imem_ready, 1);
        chk("f1_rdata", imem_rdata, 32'hC0DE_0010);
        wait_idle();

        // Fetch and load together; fetch held while pending
        op_log.delete();
        imem_addr = 16'h0020;
        mem_addr  = 32'h0000_1000;
        mem_we    = 4'b0;
        exp_f.push_back(ref_rd(32'h20));
        exp_l.push_back(ref_rd(32'h1000));
        mc = -1;
        ic = -1;
        for (int i = 0; i < 12; i++) begin
            imem_oe = (i < 4);
            mem_oe  = (i == 0);
            if (mem_ready && mc < 0) mc = i;
            if (imem_ready && ic < 0) ic = i;
            tick();
        end
        imem_oe = 1'b0;
        mem_oe  = 1'b0;
        chk("dual_load_ready_cycle", mc, 3);
        chk("dual_gap_ge2", (ic >= 0) && (ic - mc >= 2), 1);
        wait_idle();
        chk("dual_reads", op_log.size(), 2);
        if (op_log.size() == 2) begin
            chk("dual_first_addr", op_log[0].addr, 32'h1000);
            chk("dual_second_addr", op_log[1].addr, 32'h20);
        end

        // Store then load to the same word on the next cycle
        op_log.delete();
        mem_addr  = 32'h80;
        mem_we    = 4'hF;
        mem_wdata = 32'hDEAD_BEEF;
        mem_oe    = 1'b1;
        store_exp(32'h80, 4'hF, 32'hDEAD_BEEF, 1'b0);
        tick();
        do_load(32'h80, got);
        chk("sw_lw_data", got, 32'hDEAD_BEEF);
        wait_idle();
        chk("sw_lw_ops", op_log.size(), 2);
        if (op_log.size() == 2) begin
            chk("sw_lw_first_we", op_log[0].we, 4'b1111);
            chk("sw_lw_second_we", op_log[1].we, 4'b0000);
        end

        // Five byte stores with ack stalled: fourth fills, fifth drops
        op_log.delete();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_addr  = 32'h200 + 32'(i);
            mem_we    = (i < 4) ? 4'(1 << i) : 4'b0001;
            mem_wdata = (32'h11 * 32'(i + 1)) << (8 * (i % 4));
            mem_oe    = 1'b1;
            store_exp(mem_addr, mem_we, mem_wdata, i == 4);
            if (i == 3) chk("sb_not_full_at3", wbuf_full, 0);
            if (i == 4) chk("sb_full_after4", wbuf_full, 1);
            tick();
        end
        mem_oe = 1'b0;
        mem_we = 4'b0;
        chk("sb_overflow", wbuf_overflow, 1);
        stall = 1'b0;
        wait_idle();
        chk("sb_writes", op_log.size(), 4);
        if (op_log.size() == 4) chk("sb_last_addr", op_log[3].addr, 32'h203);
        do_load(32'h200, got);
        chk("sb_word", got, 32'h4433_2211);
        do_load(32'h204, got);
        chk("sb_dropped", got, 32'hC0DE_0204);
        chk("sb_overflow_sticky", wbuf_overflow, 1);
        wait_idle();

        // Load re-presented for 6 cycles, then store on the ready cycle
        op_log.delete();
        k         = 5;
        mem_addr  = 32'h300;
        mem_we    = 4'b0;
        exp_l.push_back(ref_rd(32'h300));
        for (int i = 0; i < 6; i++) begin
            mem_oe = 1'b1;
            tick();
        end
        mem_oe = 1'b0;
        nr = 0;
        for (int n = 0; n < 40 && !mem_ready; n++) tick();
        if (!mem_ready) miss("hold_timeout");
        mem_addr  = 32'h304;
        mem_we    = 4'hF;
        mem_wdata = 32'h1234_5678;
        mem_oe    = 1'b1;
        store_exp(32'h304, 4'hF, 32'h1234_5678, 1'b0);
        tick();
        mem_oe = 1'b0;
        mem_we = 4'b0;
        wait_idle();
        k = 1;
        foreach (op_log[i]) if (op_log[i].we == 4'b0) nr++;
        chk("hold_reads", nr, 1);
        chk("hold_ops", op_log.size(), 2);
        if (op_log.size() == 2) chk("hold_store_addr", op_log[1].addr, 32'h304);

        // Reset while a read is waiting for ack, then a stray ack
        op_log.delete();
        stall     = 1'b1;
        imem_addr = 16'h0040;
        imem_oe   = 1'b1;
        mem_addr  = 32'h400;
        mem_we    = 4'hF;
        mem_wdata = 32'hA5A5_A5A5;
        mem_oe    = 1'b1;
        tick();
        imem_oe = 1'b0;
        mem_oe  = 1'b0;
        mem_we  = 4'b0;
        tick();
        tick();
        chk("rr_busy", ram_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stall = 1'b0;
        chk("rr_ram_req", ram_req, 0);
        chk("rr_imem_ready", imem_ready, 0);
        chk("rr_mem_ready", mem_ready, 0);
        chk("rr_overflow", wbuf_overflow, 0);
        chk("rr_full", wbuf_full, 0);
        late_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_no_ready", {imem_ready, mem_ready}, 0);
        end
        do_load(32'h500, got);
        chk("rr_load", got, 32'hC0DE_0500);
        wait_idle();
        chk("rr_fifo_empty", op_log.size(), 1);
        if (op_log.size() == 1) chk("rr_only_read", op_log[0].we, 0);

        chk("end_fetch_q", exp_f.size(), 0);
        chk("end_load_q", exp_l.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
